sort_job_ctrl: RTL

SORT_JOB_CTRL -- requirements
Module: sort_job_ctrl

---
 rtl/sort_ctrl_pkg.sv | 23 ++
 rtl/sort_job_ctrl_rr_arbiter.sv | 66 ++++++
 rtl/sort_job_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sort_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sort_ctrl_pkg
// Shared definitions for the sort job controller: the controller FSM state
// encoding and the default values of the controller parameters.
// ----------------------------------------------------------------------------
package sort_ctrl_pkg;

    localparam int DEF_WIDTH     = 32;     // data word width
    localparam int DEF_NUM_NODES = 8500;   // words per sort job
    localparam int DEF_NUM_REQ   = 2;      // number of requesters
    localparam int DEF_CLEAR_GAP = 5;      // idle cycles after a sorter clear
    localparam int DEF_TIMEOUT   = 65535;  // max cycles to wait for a result

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_SORT = 3'd2,
        ST_RESULT    = 3'd3,
        ST_CLEAR     = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

endpackage

// File: rtl/sort_job_ctrl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The grant is combinational and one-hot: the first
// asserted request at or after the priority pointer wins. The pointer moves
// to the index after the winner only when i_upd is pulsed, so the caller
// decides when a job is really finished.
//
// Ports
//   i_clk   clock
//   i_rst   synchronous active-high reset (index 0 gets priority)
//   i_req   request vector
//   o_gnt   one-hot grant for the current request vector (all-zero if none)
//   i_upd   advance the pointer past the winner given on i_win
//   i_win   one-hot winner of the job that just completed
// ----------------------------------------------------------------------------
module rr_arbiter
    import sort_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    input  logic               i_upd,
    input  logic [NUM_REQ-1:0] i_win
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_win_idx;
    logic          w_found;

    // Scan from the pointer, wrapping around; first hit wins.
    always_comb begin
        int j;
        j       = 0;
        o_gnt   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[j]) begin
                o_gnt[j] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_win[k]) w_win_idx = IW'(k);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_upd) begin
            r_ptr <= (w_win_idx == IDX_LAST) ? '0 : w_win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sort_job_ctrl.sv
// ----------------------------------------------------------------------------
// sort_job_ctrl
// Shares one hardware sorter among NUM_REQ requesters. A requester is picked
// round-robin, streams NUM_NODES words into the sorter, waits for the sorter
// result (with a timeout), reads the result until it acknowledges, and then
// the sorter is cleared and given CLEAR_GAP idle cycles before the next job.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req            per-requester job request (sampled only in IDLE)
//   gnt            one-hot grant, held from LOAD through GAP
//   s_valid/s_data per-requester word stream (s_data packed, index 0 in LSBs)
//   s_ready        word accept, only for the granted requester during LOAD
//   res_vld        sorter results valid for the granted requester
//   res_ack        requester is done reading results
//   srt_load_en    sorter load enable (registered)
//   srt_data_in    sorter input word, all-ones when not loading
//   srt_clear      one-cycle sorter clear pulse
//   srt_out_vld    sorter result valid (only looked at in WAIT_SORT)
//   busy           controller is not idle
//   err_timeout    sticky: the sorter failed to answer within TIMEOUT cycles
// ----------------------------------------------------------------------------
module sort_job_ctrl
    import sort_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_NODES = DEF_NUM_NODES,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int CLEAR_GAP = DEF_CLEAR_GAP,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    output logic [NUM_REQ-1:0]       gnt,
    input  logic [NUM_REQ-1:0]       s_valid,
    input  logic [NUM_REQ*WIDTH-1:0] s_data,
    output logic [NUM_REQ-1:0]       s_ready,
    output logic [NUM_REQ-1:0]       res_vld,
    input  logic [NUM_REQ-1:0]       res_ack,
    output logic                     srt_load_en,
    output logic [WIDTH-1:0]         srt_data_in,
    output logic                     srt_clear,
    input  logic                     srt_out_vld,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int CW = $clog2(NUM_NODES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(CLEAR_GAP + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_NODES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_NODES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CLEAR_GAP - 1);

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_res_vld;
    logic               r_load_en;
    logic [WIDTH-1:0]   r_data;
    logic               r_clear;
    logic               r_err;
    logic [CW-1:0]      r_cnt;
    logic [TW-1:0]      r_tmo;
    logic [GW-1:0]      r_gap;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic               w_arb_upd;
    logic               w_acc;
    logic [WIDTH-1:0]   w_word;

    // Pointer advances only as the job fully completes (GAP exit), so an
    // aborted job (reset) never moves priority.
    assign w_arb_upd = (r_state == ST_GAP) && (r_gap == GAP_LAST);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_clk (clk),
        .i_rst (rst),
        .i_req (req),
        .o_gnt (w_arb_gnt),
        .i_upd (w_arb_upd),
        .i_win (r_gnt)
    );

    // s_ready follows state directly so it drops in the same cycle the
    // counter reaches NUM_NODES (state has left LOAD by then).
    assign s_ready = (r_state == ST_LOAD) ? r_gnt : '0;
    assign w_acc   = (r_state == ST_LOAD) && (|(s_valid & r_gnt));

    // Granted word select; r_gnt is one-hot so an OR of masked lanes suffices.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) w_word = w_word | s_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_res_vld <= '0;
            r_load_en <= 1'b0;
            r_data    <= '1;
            r_clear   <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_gap     <= '0;
        end else begin
            // Sorter load path: one-cycle registered copy of accepted words,
            // all-ones on bubbles and outside LOAD.
            r_load_en <= w_acc;
            r_data    <= w_acc ? w_word : '1;
            r_clear   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_gnt   <= w_arb_gnt;
                        r_cnt   <= '0;
                        r_state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (w_acc) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= CNT_FULL;
                            r_tmo   <= '0;
                            r_state <= ST_WAIT_SORT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                ST_WAIT_SORT: begin
                    if (srt_out_vld) begin
                        r_res_vld <= r_gnt;
                        r_state   <= ST_RESULT;
                    end else if (r_tmo == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_clear <= 1'b1;
                        r_state <= ST_CLEAR;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                ST_RESULT: begin
                    // Only the granted requester's ack counts.
                    if (|(res_ack & r_gnt)) begin
                        r_res_vld <= '0;
                        r_clear   <= 1'b1;
                        r_state   <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    r_gap   <= '0;
                    r_state <= ST_GAP;
                end

                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_gnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end

                default: begin
                    r_gnt     <= '0;
                    r_res_vld <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign res_vld     = r_res_vld;
    assign srt_load_en = r_load_en;
    assign srt_data_in = r_data;
    assign srt_clear   = r_clear;
    assign busy        = (r_state != ST_IDLE);
    assign err_timeout = r_err;

endmodule
